latch_write_arbiter: RTL and testbench
======================================

// Module: latch_write_arbiter
// PURPOSE
//  Shares one bank of 2**ADDR_W level-sensitive D latches (DATA_W bits each) between N_REQ
//  write requesters. Round-robin arbitration; sequences each write as a safe pulse on one
//  latch enable: setup, open, hold. Sits between bus-side requesters and the latch bank.
// PARAMETERS
//  N_REQ      4  number of requesters (>=2)
//  DATA_W     8  latch word width
//  ADDR_W     2  latch word select width; bank holds 2**ADDR_W words
//  SETUP_CYC  1  cycles latch_d is stable before enable rises (>=1)
//  OPEN_CYC   2  cycles enable is held high (>=1)
//  HOLD_CYC   1  cycles latch_d is held after enable falls (>=1)
// PORTS
//  clk          in   1               rising-edge clock
//  rst          in   1               reset: synchronous, active-high
//  req          in   N_REQ           write request per requester, level
//  req_addr     in   N_REQ*ADDR_W    word select; requester i in bits [i*ADDR_W +: ADDR_W]
//  req_data     in   N_REQ*DATA_W    write data; requester i in bits [i*DATA_W +: DATA_W]
//  ack          out  N_REQ           one-cycle completion pulse to the granted requester
//  grant_id     out  $clog2(N_REQ)   index of current/last granted requester
//  busy         out  1               high in any state other than IDLE
//  latch_d      out  DATA_W          data bus to all latch d inputs
//  latch_en     out  2**ADDR_W       per-word latch enable; at most one bit high
// BEHAVIOUR
//  - All outputs registered. On reset: state=IDLE; ack=0; latch_en=0; latch_d=0; busy=0;
//    grant_id=0; RR pointer=N_REQ-1, so requester 0 has top priority first.
//  - FSM IDLE -> SETUP -> OPEN -> HOLD -> DONE -> IDLE. A per-state down-counter is loaded on
//    entry; the state is left when the counter expires.
//  - IDLE: if any req bit is high, grant the first set bit searching from pointer+1 upward
//    with wrap. At that edge: capture the winner's addr/data into internal regs,
//    latch_d<=data, grant_id<=winner, pointer<=winner, go SETUP. No req: stay IDLE.
//  - SETUP lasts SETUP_CYC cycles with latch_en=0. OPEN lasts OPEN_CYC cycles with
//    latch_en = onehot(addr). HOLD lasts HOLD_CYC cycles with latch_en=0 and latch_d still
//    held. DONE lasts 1 cycle with ack[grant_id]=1.
//  - Latency: req high in IDLE at cycle t gives ack in cycle t+1+SETUP+OPEN+HOLD
//    (t+5 with defaults). latch_d never changes while any latch_en bit is high, or in the
//    SETUP/HOLD windows.
//  - Handshake: the requester keeps req high until ack. req still high in the cycle after
//    ack counts as a new request. Changing or dropping req/addr/data after grant has no
//    effect: the captured write completes and ack is still issued.
//  - Back-to-back: DONE->IDLE costs one idle cycle. Minimum write period is
//    2+SETUP+OPEN+HOLD cycles.
//  - Fairness: with all requesters constantly asserting, grants rotate 0,1,..,N_REQ-1,0,..
//  - Writes to the same address by different requesters are serialised in grant order.
//    The last one wins.
//  - rst mid-transaction: next edge forces the reset values. The aborted write gets no ack.
//    The latch word keeps whatever it captured.
// CONFIGURATION
//  - LATCH_READBACK_EN defined: adds input latch_q_sel [DATA_W] (mux of the bank's q, selected
//    by the write addr) and output wr_err [1], reset 0.
//    - In DONE, wr_err <= (latch_q_sel != latch_d). It is a one-cycle pulse coincident with ack.
//  - Not defined: these ports do not exist and no compare logic is built.
// TESTING
//  1. Reset, then req=4'b0001, addr0=2, data0=8'hA5: latch_d=A5 from t+1; latch_en=4'b0100
//     for exactly 2 cycles; ack[0] in cycle t+5; busy high t+1..t+5.
//  2. req=4'b1111 held through 8 acks: grant_id order 0,1,2,3,0,1,2,3; each ack is 1 cycle;
//     ack period is 6 cycles.
//  3. Grant req1 (addr=1, data=8'h3C), then change data1 to 8'hFF and drop req1 during OPEN:
//     latch_d stays 3C through HOLD; ack[1] still issued.
//  4. Assert rst in the OPEN cycle: next cycle latch_en=0, latch_d=0, busy=0; no ack. The
//     next req=4'b0100 is granted to requester 2 with full timing.
//  5. Override to SETUP=2, OPEN=3, HOLD=2: single request acks at t+8; latch_en high for
//     exactly 3 cycles; latch_d stable from t+1 to t+8.
//  6. With LATCH_READBACK_EN defined, write 8'h5A with latch_q_sel driven 8'h5B:
//     wr_err=1 with ack. Driven 8'h5A: wr_err=0.

Source files
------------

// File: rtl/latch_write_arbiter_if.sv
// Requester/latch-bank bundle for latch_write_arbiter.
// LATCH_READBACK_EN adds latch_q_sel / wr_err.
interface latch_write_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
);
  localparam int ID_W   = $clog2(N_REQ);
  localparam int N_WORD = 2 ** ADDR_W;

  logic [N_REQ-1:0]        req;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        ack;
  logic [ID_W-1:0]         grant_id;
  logic                    busy;
  logic [DATA_W-1:0]       latch_d;
  logic [N_WORD-1:0]       latch_en;
`ifdef LATCH_READBACK_EN
  logic [DATA_W-1:0]       latch_q_sel;
  logic                    wr_err;

  modport master (
    output req, req_addr, req_data, latch_q_sel,
    input  ack, grant_id, busy, latch_d, latch_en, wr_err
  );
  modport slave (
    input  req, req_addr, req_data, latch_q_sel,
    output ack, grant_id, busy, latch_d, latch_en, wr_err
  );
`else
  modport master (
    output req, req_addr, req_data,
    input  ack, grant_id, busy, latch_d, latch_en
  );
  modport slave (
    input  req, req_addr, req_data,
    output ack, grant_id, busy, latch_d, latch_en
  );
`endif
endinterface

// File: rtl/latch_write_arbiter.sv
// Round-robin writer for a shared D-latch bank: setup/open/hold pulse per write.
// LATCH_READBACK_EN adds a post-write compare (wr_err).
module latch_write_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 2,
  parameter int SETUP_CYC = 1,
  parameter int OPEN_CYC  = 2,
  parameter int HOLD_CYC  = 1
) (
  input logic clk,
  input logic rst,
  latch_write_arbiter_if.slave bus
);
  localparam int ID_W   = $clog2(N_REQ);
  localparam int N_WORD = 2 ** ADDR_W;
  localparam int MAXC_A = (SETUP_CYC > OPEN_CYC) ? SETUP_CYC : OPEN_CYC;
  localparam int MAXC   = (MAXC_A > HOLD_CYC) ? MAXC_A : HOLD_CYC;
  localparam int CW     = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_OPEN,
    S_HOLD,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   gid_q, gid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] ld_q, ld_d;
  logic [N_WORD-1:0] en_q, en_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              found;
  logic [ID_W-1:0]   win;
  int                idx;

  // first requester after the last winner, wrapping
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(ptr_q) + k) % N_REQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    addr_d  = addr_q;
    ld_d    = ld_q;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_SETUP;
          cnt_d   = CW'(SETUP_CYC - 1);
          gid_d   = win;
          ptr_d   = win;
          addr_d  = bus.req_addr[win*ADDR_W +: ADDR_W];
          ld_d    = bus.req_data[win*DATA_W +: DATA_W];
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_OPEN;
          cnt_d   = CW'(OPEN_CYC - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_OPEN: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          cnt_d   = CW'(HOLD_CYC - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // outputs are registered images of the next state
    en_d   = (state_d == S_OPEN) ? (N_WORD'(1) << addr_d) : '0;
    ack_d  = (state_d == S_DONE) ? (N_REQ'(1) << gid_d) : '0;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= ID_W'(N_REQ - 1);
      gid_q   <= '0;
      addr_q  <= '0;
      ld_q    <= '0;
      en_q    <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      addr_q  <= addr_d;
      ld_q    <= ld_d;
      en_q    <= en_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.grant_id = gid_q;
  assign bus.busy     = busy_q;
  assign bus.latch_d  = ld_q;
  assign bus.latch_en = en_q;

`ifdef LATCH_READBACK_EN
  logic wr_err_q, wr_err_d;

  always_comb begin
    wr_err_d = 1'b0;
    if (state_d == S_DONE) begin
      wr_err_d = (bus.latch_q_sel != ld_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= wr_err_d;
    end
  end

  assign bus.wr_err = wr_err_q;
`endif
endmodule

// File: tb/tb_latch_write_arbiter.sv
// Directed bench for latch_write_arbiter (default and stretched timing).
// Readback checks run when LATCH_READBACK_EN is defined.
module tb_latch_write_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  latch_write_arbiter_if #(.N_REQ(4), .DATA_W(8), .ADDR_W(2)) bus ();
  latch_write_arbiter_if #(.N_REQ(4), .DATA_W(8), .ADDR_W(2)) bus5 ();

  latch_write_arbiter #(
    .N_REQ(4), .DATA_W(8), .ADDR_W(2),
    .SETUP_CYC(1), .OPEN_CYC(2), .HOLD_CYC(1)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  latch_write_arbiter #(
    .N_REQ(4), .DATA_W(8), .ADDR_W(2),
    .SETUP_CYC(2), .OPEN_CYC(3), .HOLD_CYC(2)
  ) dut5 (
    .clk(clk), .rst(rst), .bus(bus5.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int last_ack;
    int n;
    logic [3:0] exp_en;
    bus.req = '0;
    bus.req_addr = '0;
    bus.req_data = '0;
    bus5.req = '0;
    bus5.req_addr = '0;
    bus5.req_data = '0;
`ifdef LATCH_READBACK_EN
    bus.latch_q_sel = '0;
    bus5.latch_q_sel = '0;
`endif

    // reset state
    rst = 1'b1;
    tick();
    tick();
    chk("rst_en", bus.latch_en, 0);
    chk("rst_d", bus.latch_d, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ack", bus.ack, 0);
    chk("rst_gid", bus.grant_id, 0);
    rst = 1'b0;

    // 1: single write, requester 0, addr 2, data A5
    bus.req = 4'b0001;
    bus.req_addr[1:0] = 2'd2;
    bus.req_data[7:0] = 8'hA5;
    tick();
    chk("t1_setup_d", bus.latch_d, 8'hA5);
    chk("t1_setup_en", bus.latch_en, 0);
    chk("t1_setup_busy", bus.busy, 1);
    tick();
    chk("t1_open1_en", bus.latch_en, 4'b0100);
    tick();
    chk("t1_open2_en", bus.latch_en, 4'b0100);
    chk("t1_open2_ack", bus.ack, 0);
    tick();
    chk("t1_hold_en", bus.latch_en, 0);
    chk("t1_hold_d", bus.latch_d, 8'hA5);
    chk("t1_hold_busy", bus.busy, 1);
    tick();
    chk("t1_done_ack", bus.ack, 4'b0001);
    chk("t1_done_busy", bus.busy, 1);
    bus.req = '0;
    tick();
    chk("t1_idle_ack", bus.ack, 0);
    chk("t1_idle_busy", bus.busy, 0);

    // 2: all requesting, rotation from requester 0 after reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      bus.req_addr[i*2 +: 2] = 2'(i);
      bus.req_data[i*8 +: 8] = 8'(8'h10 + i);
    end
    last_ack = -1;
    for (int a = 0; a < 8; a++) begin
      n = 0;
      while (bus.ack == 0 && n < 20) begin
        tick();
        n++;
      end
      chk($sformatf("t2_ack%0d", a), bus.ack, 4'b0001 << (a % 4));
      chk($sformatf("t2_gid%0d", a), bus.grant_id, a % 4);
      if (last_ack >= 0) begin
        chk($sformatf("t2_per%0d", a), cyc - last_ack, 6);
      end
      last_ack = cyc;
      if (a == 7) bus.req = '0;
      tick();
      chk($sformatf("t2_pulse%0d", a), bus.ack, 0);
    end

    // 3: inputs change after grant; captured write completes
    bus.req = 4'b0010;
    bus.req_addr[3:2] = 2'd1;
    bus.req_data[15:8] = 8'h3C;
    tick();
    chk("t3_gid", bus.grant_id, 1);
    chk("t3_setup_d", bus.latch_d, 8'h3C);
    tick();
    chk("t3_open_en", bus.latch_en, 4'b0010);
    bus.req = '0;
    bus.req_data[15:8] = 8'hFF;
    tick();
    chk("t3_open2_d", bus.latch_d, 8'h3C);
    chk("t3_open2_en", bus.latch_en, 4'b0010);
    tick();
    chk("t3_hold_d", bus.latch_d, 8'h3C);
    chk("t3_hold_en", bus.latch_en, 0);
    tick();
    chk("t3_ack", bus.ack, 4'b0010);
    tick();
    chk("t3_idle_ack", bus.ack, 0);

    // 4: reset during OPEN aborts write
    bus.req = 4'b0001;
    bus.req_addr[1:0] = 2'd3;
    bus.req_data[7:0] = 8'h77;
    tick();
    tick();
    chk("t4_open_en", bus.latch_en, 4'b1000);
    rst = 1'b1;
    bus.req = '0;
    tick();
    chk("t4_rst_en", bus.latch_en, 0);
    chk("t4_rst_d", bus.latch_d, 0);
    chk("t4_rst_busy", bus.busy, 0);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("t4_noack%0d", k), bus.ack, 0);
    end
    bus.req = 4'b0100;
    bus.req_addr[5:4] = 2'd0;
    bus.req_data[23:16] = 8'h42;
    tick();
    chk("t4_gid", bus.grant_id, 2);
    chk("t4_setup_d", bus.latch_d, 8'h42);
    chk("t4_setup_en", bus.latch_en, 0);
    tick();
    chk("t4_open1_en", bus.latch_en, 4'b0001);
    tick();
    chk("t4_open2_en", bus.latch_en, 4'b0001);
    tick();
    chk("t4_hold_en", bus.latch_en, 0);
    tick();
    chk("t4_ack", bus.ack, 4'b0100);
    bus.req = '0;
    tick();
    chk("t4_idle_ack", bus.ack, 0);

    // 5: SETUP=2 OPEN=3 HOLD=2 instance
    bus5.req = 4'b1000;
    bus5.req_addr[7:6] = 2'd3;
    bus5.req_data[31:24] = 8'hC3;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_en = (k >= 3 && k <= 5) ? 4'b1000 : 4'b0000;
      chk($sformatf("t5_d%0d", k), bus5.latch_d, 8'hC3);
      chk($sformatf("t5_en%0d", k), bus5.latch_en, exp_en);
      chk($sformatf("t5_ack%0d", k), bus5.ack, (k == 8) ? 4'b1000 : 4'b0000);
      chk($sformatf("t5_busy%0d", k), bus5.busy, 1);
      if (k == 8) bus5.req = '0;
    end
    tick();
    chk("t5_idle_ack", bus5.ack, 0);
    chk("t5_idle_busy", bus5.busy, 0);

`ifdef LATCH_READBACK_EN
    // 6: readback compare
    bus.req = 4'b0001;
    bus.req_addr[1:0] = 2'd2;
    bus.req_data[7:0] = 8'h5A;
    bus.latch_q_sel = 8'h5B;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("t6a_err%0d", k), bus.wr_err, 0);
    end
    tick();
    chk("t6a_ack", bus.ack, 4'b0001);
    chk("t6a_err", bus.wr_err, 1);
    bus.req = '0;
    tick();
    chk("t6a_err_pulse", bus.wr_err, 0);
    bus.req = 4'b0001;
    bus.latch_q_sel = 8'h5A;
    for (int k = 1; k <= 4; k++) tick();
    tick();
    chk("t6b_ack", bus.ack, 4'b0001);
    chk("t6b_err", bus.wr_err, 0);
    bus.req = '0;
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
